// File: rtl/rv32i_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// rv32i_wb_arbiter_if
// Bus bundle between the write-back requesters, the register file and
// rv32i_wb_arbiter.
//   req_valid   [NUM_REQ]     requester i has a write pending
//   req_reg     [5*NUM_REQ]   destination index, requester i at [5i+4:5i]
//   req_data    [32*NUM_REQ]  write data, requester i at [32i+31:32i]
//   req_ready   [NUM_REQ]     one-hot grant for this cycle
//   wb_enable/wb_reg/wb_data  registered register-file write port
//   stall                     some requester is valid but not granted
//   rs1_reg/rs2_reg           read indices presented to the register file
//   rf_rs1_data/rf_rs2_data   raw register-file read data
//   rs1_data/rs2_data         read data delivered to the datapath
// Modports: slave = arbiter side, master = requester/datapath side.
// -----------------------------------------------------------------------------
interface rv32i_wb_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [5*NUM_REQ-1:0]  req_reg;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  wb_enable;
    logic [4:0]            wb_reg;
    logic [31:0]           wb_data;
    logic                  stall;
    logic [4:0]            rs1_reg;
    logic [4:0]            rs2_reg;
    logic [31:0]           rf_rs1_data;
    logic [31:0]           rf_rs2_data;
    logic [31:0]           rs1_data;
    logic [31:0]           rs2_data;

    modport slave (
        input  req_valid, req_reg, req_data, rs1_reg, rs2_reg, rf_rs1_data, rf_rs2_data,
        output req_ready, wb_enable, wb_reg, wb_data, stall, rs1_data, rs2_data
    );

    modport master (
        output req_valid, req_reg, req_data, rs1_reg, rs2_reg, rf_rs1_data, rf_rs2_data,
        input  req_ready, wb_enable, wb_reg, wb_data, stall, rs1_data, rs2_data
    );
endinterface

// File: rtl/rv32i_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rv32i_wb_arbiter
// Round-robin arbiter sharing the single RV32I register-file write port among
// NUM_REQ requesters (default 0=ALU, 1=LOAD, 2=CSR).
// Ports:
//   clk    system clock, all state on posedge
//   reset  asynchronous, active-low reset
//   bus    rv32i_wb_arbiter_if.slave (request handshake, write port, read data)
// Optional feature: define WB_BYPASS_EN to forward the in-flight registered
// write to rs1_data/rs2_data; otherwise the read data passes straight through.
// -----------------------------------------------------------------------------
module rv32i_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    rv32i_wb_arbiter_if.slave   bus
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             wb_enable_q, wb_enable_d;
    logic [4:0]       wb_reg_q, wb_reg_d;
    logic [31:0]      wb_data_q, wb_data_d;

    logic             lo_hit, hi_hit, grant_any;
    logic [PTR_W-1:0] lo_win, hi_win, winner;
    logic [4:0]       sel_reg;
    logic [31:0]      sel_data;

    // Rotating priority without a variable index: the lowest valid requester
    // at or above ptr wins; failing that, the lowest valid requester overall
    // (the wrap-around part of the scan).
    always_comb begin
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        lo_win = '0;
        hi_win = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && !lo_hit) begin
                lo_hit = 1'b1;
                lo_win = PTR_W'(i);
            end
            if (bus.req_valid[i] && !hi_hit && i >= 32'(ptr_q)) begin
                hi_hit = 1'b1;
                hi_win = PTR_W'(i);
            end
        end
        winner    = hi_hit ? hi_win : lo_win;
        // No grant is issued while reset is held.
        grant_any = lo_hit && reset;
    end

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(winner) == i) begin
                sel_reg  = bus.req_reg[i*5 +: 5];
                sel_data = bus.req_data[i*32 +: 32];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        wb_enable_d = 1'b0;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        if (grant_any) begin
            ptr_d       = (32'(winner) == NUM_REQ - 1) ? '0 : winner + PTR_W'(1);
            wb_enable_d = (sel_reg != 5'd0);
            wb_reg_d    = sel_reg;
            wb_data_d   = sel_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            wb_enable_q <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            wb_enable_q <= wb_enable_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign bus.req_ready = grant_any ? (NUM_REQ'(1) << winner) : '0;
    assign bus.stall     = |(bus.req_valid & ~bus.req_ready);
    assign bus.wb_enable = wb_enable_q;
    assign bus.wb_reg    = wb_reg_q;
    assign bus.wb_data   = wb_data_q;

`ifdef WB_BYPASS_EN
    // x0 never forwards because wb_enable is never set for an x0 write.
    assign bus.rs1_data = (wb_enable_q && wb_reg_q == bus.rs1_reg) ? wb_data_q : bus.rf_rs1_data;
    assign bus.rs2_data = (wb_enable_q && wb_reg_q == bus.rs2_reg) ? wb_data_q : bus.rf_rs2_data;
`else
    assign bus.rs1_data = bus.rf_rs1_data;
    assign bus.rs2_data = bus.rf_rs2_data;
`endif

endmodule
